uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg_pkg.sv | 36 +++
 rtl/uart_rx_cfg_sync_filter.sv | 42 ++++
 rtl/uart_rx_cfg.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_rx_cfg_pkg;

  // Number of line samples voted on around each bit centre.
  localparam int unsigned MajTaps = 3;

  typedef enum logic [1:0] {
    ParNone = 2'b00,
    ParEven = 2'b01,
    ParOdd  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StBrkWait
  } uart_rx_state_e;

  // Mode 2'b11 is treated as no parity.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return ParEven;
      2'b10:   return ParOdd;
      default: return ParNone;
    endcase
  endfunction

  function automatic logic majority3(input logic [MajTaps-1:0] taps);
    return (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_filter.sv
// Line conditioning: metastability synchronizer followed by a 3-tap majority filter.
module uart_rx_cfg_sync_filter
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_sync,
  output logic o_fall,
  output logic o_vote
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [MajTaps-1:0]    taps_q, taps_d;

  // Shift the raw pin through the synchronizer, then into the vote window.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], i_rx};
    taps_d = {taps_q[MajTaps-2:0], sync_q[SyncStages-1]};
  end

  // Idle-high line: preset everything to 1 so reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '1;
      taps_q <= '1;
    end else begin
      sync_q <= sync_d;
      taps_q <= taps_d;
    end
  end

  // taps_q[0] is the previous synced value, so this is a 1->0 edge of the synced line.
  always_comb begin
    o_sync = sync_q[SyncStages-1];
    o_fall = taps_q[0] & ~sync_q[SyncStages-1];
    o_vote = majority3(taps_q);
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime parity/stop config, majority sampling,
// valid/ready output with parity, framing, overrun and break reporting.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned OverSample = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic [1:0]           i_parity,
  input  logic                 i_stop2,
  input  logic                 i_err_clr,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int unsigned TickW = $clog2(OverSample);
  localparam int unsigned BitW  = $clog2(DataWidth);
  localparam logic [TickW-1:0] TickMid = TickW'(OverSample / 2);
  localparam logic [TickW-1:0] TickEnd = TickW'(OverSample - 1);
  localparam logic [BitW-1:0]  BitLast = BitW'(DataWidth - 1);

  logic rx_sync, rx_fall, rx_vote;

  uart_rx_cfg_sync_filter #(
    .SyncStages (SyncStages)
  ) u_sync_filter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_rx),
    .o_sync  (rx_sync),
    .o_fall  (rx_fall),
    .o_vote  (rx_vote)
  );

  uart_rx_state_e       state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  parity_e              par_mode_q, par_mode_d;
  logic                 stop2_q, stop2_d;
  logic                 pbit_q, pbit_d;
  logic                 fperr_q, fperr_d;
  logic                 s1_q, s1_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 break_q, break_d;
  logic                 eof, eof_ferr, sample_end;

  // Frame FSM: after the start-bit check, bit centres land on the tick wrap.
  always_comb begin
    state_d    = state_q;
    tick_d     = (tick_q == TickEnd) ? '0 : tick_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    pbit_d     = pbit_q;
    fperr_d    = fperr_q;
    s1_d       = s1_q;
    break_d    = 1'b0;
    eof        = 1'b0;
    eof_ferr   = 1'b0;
    sample_end = (tick_q == TickEnd);
    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          state_d    = StStart;
          par_mode_d = decode_parity(i_parity);
          stop2_d    = i_stop2;
        end
      end
      StStart: begin
        if (tick_q == TickMid) begin
          if (rx_vote) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
            pbit_d  = 1'b0;
            fperr_d = 1'b0;
          end
        end
      end
      StData: begin
        if (sample_end) begin
          shift_d = {rx_vote, shift_q[DataWidth-1:1]};
          if (bit_q == BitLast) begin
            state_d = (par_mode_q != ParNone) ? StParity : StStop1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (sample_end) begin
          pbit_d  = rx_vote;
          fperr_d = (^shift_q ^ rx_vote) != (par_mode_q == ParOdd);
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (sample_end) begin
          s1_d = rx_vote;
          // pbit_q stays 0 when parity is off, so it drops out of the break test.
          if (shift_q == '0 && !pbit_q && !rx_vote) begin
            break_d = 1'b1;
            state_d = StBrkWait;
          end else if (stop2_q) begin
            state_d = StStop2;
          end else begin
            eof      = 1'b1;
            eof_ferr = ~rx_vote;
            state_d  = StIdle;
          end
        end
      end
      StStop2: begin
        if (sample_end) begin
          eof      = 1'b1;
          eof_ferr = ~s1_q | ~rx_vote;
          state_d  = StIdle;
        end
      end
      StBrkWait: begin
        if (rx_sync) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      tick_d = '0;
    end
  end

  // Output holding register: load when empty or being drained, else flag overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q & ~i_err_clr;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (eof) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        perr_d  = fperr_q;
        ferr_d  = eof_ferr;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_mode_q <= ParNone;
      stop2_q    <= 1'b0;
      pbit_q     <= 1'b0;
      fperr_q    <= 1'b0;
      s1_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      pbit_q     <= pbit_d;
      fperr_q    <= fperr_d;
      s1_q       <= s1_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
      break_q    <= break_d;
    end
  end

  // Drive ports straight from state.
  always_comb begin
    o_data       = data_q;
    o_valid      = valid_q;
    o_parity_err = perr_q;
    o_frame_err  = ferr_q;
    o_overrun    = overrun_q;
    o_break      = break_q;
    o_busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are built bit by bit on the line,
// expected words are queued at send time and checked when the consumer accepts.
module tb_uart_rx_cfg;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [1:0]    parity;
  logic          stop2;
  logic          err_clr;
  logic          ready;
  logic [DW-1:0] data;
  logic          valid, perr, ferr, overrun, brk, busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_checks = 0;
  int   n_bad    = 0;
  int   acc_cnt  = 0;
  int   vhi_cnt  = 0;
  int   brk_cnt  = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .DataWidth  (DW),
    .OverSample (OS),
    .SyncStages (SS)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .i_parity     (parity),
    .i_stop2      (stop2),
    .i_err_clr    (err_clr),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_parity_err (perr),
    .o_frame_err  (ferr),
    .o_overrun    (overrun),
    .o_break      (brk),
    .o_busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(OS);
  endtask

  // pm: 0 none, 1 even, 2 odd. pbit is driven as given so errors can be injected.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic st1, input logic st2, input logic two,
                            input logic push);
    exp_t e;
    logic pexp;
    logic has_par;
    has_par = (pm == 2'b01) || (pm == 2'b10);
    parity  = pm;
    stop2   = two;
    if (push) begin
      pexp   = (pm == 2'b10) ? ~(^d) : ^d;
      e.data = d;
      e.perr = has_par && (pbit != pexp);
      e.ferr = ~st1 | (two & ~st2);
      sb.push_back(e);
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(st1);
    if (two) send_bit(st2);
    rx = 1'b1;
  endtask

  // Consumer-side monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) vhi_cnt++;
      if (brk) brk_cnt++;
      if (valid && ready) begin
        acc_cnt++;
        check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          check_val("word_data", 32'(data), 32'(got_e.data));
          check_val("word_perr", 32'(perr), 32'(got_e.perr));
          check_val("word_ferr", 32'(ferr), 32'(got_e.ferr));
        end
      end
    end
  end

  initial begin
    int v0;
    int a0;
    int b0;
    rst_n   = 1'b0;
    rx      = 1'b1;
    parity  = 2'b00;
    stop2   = 1'b0;
    err_clr = 1'b0;
    ready   = 1'b1;
    tick(3);
    check_val("rst_valid", 32'(valid), 0);
    check_val("rst_data", 32'(data), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_overrun", 32'(overrun), 0);
    check_val("rst_break", 32'(brk), 0);
    rst_n = 1'b1;
    tick(5);

    // 8N1 0xA5 with a ready consumer: single-cycle valid.
    v0 = vhi_cnt;
    a0 = acc_cnt;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);
    check_val("a5_valid_cycles", 32'(vhi_cnt - v0), 1);
    check_val("a5_accepted", 32'(acc_cnt - a0), 1);

    // Parity: even with wrong and right bit, then odd.
    send_frame(8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);
    send_frame(8'h07, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);
    send_frame(8'h07, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);

    // Short low glitch must be rejected at the start-bit check.
    a0 = acc_cnt;
    parity = 2'b00;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    check_val("glitch_busy", 32'(busy), 0);
    check_val("glitch_no_word", 32'(acc_cnt - a0), 0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);

    // Overrun: consumer stalled, second frame dropped.
    ready = 1'b0;
    a0 = acc_cnt;
    send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(10);
    check_val("ovr_valid_held", 32'(valid), 1);
    check_val("ovr_data_held", 32'(data), 32'h11);
    check_val("ovr_flag", 32'(overrun), 1);
    ready = 1'b1;
    tick(3);
    check_val("ovr_drained", 32'(valid), 0);
    check_val("ovr_one_word", 32'(acc_cnt - a0), 1);
    check_val("ovr_sticky", 32'(overrun), 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_val("ovr_cleared", 32'(overrun), 0);

    // Two stop bits with the second low, then a clean single-stop frame.
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(20);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);

    // Break: line low for three frame times.
    a0 = acc_cnt;
    b0 = brk_cnt;
    parity = 2'b00;
    stop2  = 1'b0;
    rx = 1'b0;
    tick(3 * 10 * OS);
    check_val("brk_pulses", 32'(brk_cnt - b0), 1);
    check_val("brk_no_word", 32'(acc_cnt - a0), 0);
    check_val("brk_wait_busy", 32'(busy), 1);
    rx = 1'b1;
    tick(20);
    check_val("brk_released", 32'(busy), 0);
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);

    // Reset mid-DATA while a word is held: everything clears.
    ready = 1'b0;
    send_frame(8'h33, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(10);
    check_val("pre_rst_valid", 32'(valid), 1);
    rx = 1'b0;
    tick(OS);
    rx = 1'b1;
    tick(3 * OS);
    check_val("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick(2);
    check_val("mid_rst_valid", 32'(valid), 0);
    check_val("mid_rst_data", 32'(data), 0);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_perr", 32'(perr), 0);
    check_val("mid_rst_ferr", 32'(ferr), 0);
    sb.delete();
    rst_n = 1'b1;
    ready = 1'b1;
    a0 = acc_cnt;
    tick(12 * OS);
    check_val("post_rst_no_word", 32'(acc_cnt - a0), 0);
    check_val("post_rst_idle", 32'(busy), 0);

    check_val("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
